// File: rtl/cpu_types_pkg.sv
// Shared CPU types and RAM defaults for the memory access controller.
// Holds the RAM status encoding, the word type and the alignment/range check helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT   = 2;
    localparam int RAM_DEPTH_DEFAULT = 16384;

    // True when the byte address is word aligned and inside a DEPTH-word storage.
    function automatic logic ram_addr_ok(input word_t addr, input int depth);
        word_t limit;
        limit = word_t'(depth) << 2;
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/ram_access_ctrl_ram_array.sv
// Word storage for ram_access_ctrl: synchronous write, asynchronous read, no reset.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH_DEFAULT,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  word_t            i_wdata,
    output word_t            o_rdata
);

    word_t r_mem [DEPTH];

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ram_access_ctrl.sv
// Latency-modelling RAM access controller: FREE/BUSY/ACCESS/ERROR handshake to an arbiter.
// Optional build macro RAM_BOUNDS_CHK_EN turns misaligned/out-of-range accesses into ERROR.
module ram_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEFAULT,
    parameter int DEPTH = RAM_DEPTH_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int         IDX_W      = $clog2(DEPTH);
    localparam logic [3:0] CNT_RELOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    ramstate_t        r_state;
    ramstate_t        w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    word_t            r_addr;
    word_t            w_addr_nxt;
    logic             r_ren;
    logic             w_ren_nxt;
    logic             r_wen;
    logic             w_wen_nxt;
    word_t            r_data;
    word_t            w_data_nxt;

    logic             w_valid;
    logic             w_both;
    logic             w_sig_diff;
    logic             w_in_ok;
    logic             w_lat_ok;
    logic             w_we;
    logic [IDX_W-1:0] w_idx;
    word_t            w_rdata;

    assign w_valid    = ramREN ^ ramWEN;
    assign w_both     = ramREN & ramWEN;
    assign w_sig_diff = (ramaddr != r_addr) || (ramREN != r_ren) || (ramWEN != r_wen);

`ifdef RAM_BOUNDS_CHK_EN
    assign w_in_ok  = ram_addr_ok(ramaddr, DEPTH);
    assign w_lat_ok = ram_addr_ok(r_addr, DEPTH);
`else
    assign w_in_ok  = 1'b1;
    assign w_lat_ok = 1'b1;
`endif

    // Next-state, counter and request-signature logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_ren_nxt   = r_ren;
        w_wen_nxt   = r_wen;
        w_data_nxt  = r_data;
        case (r_state)
            BUSY: begin
                if (!ramREN && !ramWEN) begin
                    w_state_nxt = FREE;
                end else if (w_both) begin
                    w_state_nxt = ERROR;
                end else if (w_sig_diff) begin
                    // Arbiter changed its mind: treat as a fresh request and wait full latency.
                    w_addr_nxt = ramaddr;
                    w_ren_nxt  = ramREN;
                    w_wen_nxt  = ramWEN;
                    w_data_nxt = ramWEN ? ramstore : 32'h0;
                    w_cnt_nxt  = CNT_RELOAD;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = w_lat_ok ? ACCESS : ERROR;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            FREE, ACCESS, ERROR: begin
                if (w_both) begin
                    w_state_nxt = ERROR;
                end else if (w_valid) begin
                    w_addr_nxt = ramaddr;
                    w_ren_nxt  = ramREN;
                    w_wen_nxt  = ramWEN;
                    w_data_nxt = ramWEN ? ramstore : 32'h0;
                    if (LAT == 0) begin
                        w_state_nxt = w_in_ok ? ACCESS : ERROR;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = CNT_RELOAD;
                    end
                end else begin
                    w_state_nxt = FREE;
                end
            end
            default: begin
                w_state_nxt = FREE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter and latched request registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FREE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_data  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_ren   <= w_ren_nxt;
            r_wen   <= w_wen_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Word index wraps modulo DEPTH since upper address bits are dropped.
    assign w_idx = r_addr[IDX_W+1:2];
    assign w_we  = (r_state == ACCESS) && r_wen;

    ram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram_array (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

    assign ramstate = r_state;
    assign ramload  = ((r_state == ACCESS) && r_ren) ? w_rdata : 32'h0;

endmodule
